// File: rtl/vx_afu_run_ctrl_if.sv
// Per-bank AXI transaction fire strobes seen by the AFU run controller.
// Master drives the strobes, the run controller consumes them.
interface vx_afu_run_ctrl_if #(
  parameter int NUM_BANKS = 2
);
  logic [NUM_BANKS-1:0] awfire;
  logic [NUM_BANKS-1:0] bfire;
  logic [NUM_BANKS-1:0] arfire;
  logic [NUM_BANKS-1:0] rlastfire;

  modport master (
    output awfire,
    output bfire,
    output arfire,
    output rlastfire
  );

  modport slave (
    input awfire,
    input bfire,
    input arfire,
    input rlastfire
  );
endinterface

// File: rtl/vx_afu_run_ctrl.sv
// Kernel run controller: reset/start/busy/drain lifecycle with
// per-bank outstanding AXI tracking, timeout and sticky errors.
module vx_afu_run_ctrl #(
  parameter int NUM_BANKS    = 2,
  parameter int CTR_WIDTH    = 16,
  parameter int RESET_DELAY  = 16,
  parameter int BUSY_TIMEOUT = 1024
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic        ap_reset,
  input  logic        ap_start,
  output logic        ap_done,
  output logic        ap_idle,
  output logic        ap_ready,
  output logic        vx_reset,
  input  logic        vx_busy,
  vx_afu_run_ctrl_if.slave axi,
  output logic        pending_any,
  output logic [63:0] run_cycles,
  output logic        err_overflow,
  output logic        err_underflow,
  output logic        err_timeout
);

  localparam int MAXS =
    (RESET_DELAY > BUSY_TIMEOUT) ? RESET_DELAY : BUSY_TIMEOUT;
  localparam int STEP_W = $clog2(MAXS + 1);
  localparam logic [STEP_W-1:0] RD_LAST =
    STEP_W'(RESET_DELAY - 1);
  localparam logic [STEP_W-1:0] TO_LAST =
    STEP_W'((BUSY_TIMEOUT == 0) ? 0 : BUSY_TIMEOUT - 1);
  localparam bit TO_EN = (BUSY_TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_WAIT,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t              state;
  logic [STEP_W-1:0]   step;
  logic                start_acc;

  logic [CTR_WIDTH-1:0] wr_cnt [NUM_BANKS];
  logic [CTR_WIDTH-1:0] rd_cnt [NUM_BANKS];
  logic [CTR_WIDTH-1:0] wr_nxt [NUM_BANKS];
  logic [CTR_WIDTH-1:0] rd_nxt [NUM_BANKS];
  logic                 ovf_any;
  logic                 unf_any;

  assign start_acc = (state == S_IDLE) && ap_start;
  assign ap_ready  = ap_done;

  // Returns {overflow, underflow, next count}; net-zero events hold.
  function automatic logic [CTR_WIDTH+1:0] ctr_next(
    input logic [CTR_WIDTH-1:0] c,
    input logic                 inc,
    input logic                 dec
  );
    logic                 ovf;
    logic                 unf;
    logic [CTR_WIDTH-1:0] n;
    ovf = 1'b0;
    unf = 1'b0;
    n   = c;
    unique case (1'b1)
      (inc & ~dec): begin
        if (&c) ovf = 1'b1;
        else    n   = c + CTR_WIDTH'(1);
      end
      (dec & ~inc): begin
        if (c == '0) unf = 1'b1;
        else         n   = c - CTR_WIDTH'(1);
      end
      default: ;
    endcase
    return {ovf, unf, n};
  endfunction

  always_comb begin
    logic [CTR_WIDTH+1:0] w;
    logic [CTR_WIDTH+1:0] r;
    ovf_any     = 1'b0;
    unf_any     = 1'b0;
    pending_any = 1'b0;
    w           = '0;
    r           = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      w = ctr_next(wr_cnt[i], axi.awfire[i], axi.bfire[i]);
      r = ctr_next(rd_cnt[i], axi.arfire[i], axi.rlastfire[i]);
      wr_nxt[i]   = w[CTR_WIDTH-1:0];
      rd_nxt[i]   = r[CTR_WIDTH-1:0];
      ovf_any     = ovf_any | w[CTR_WIDTH+1] | r[CTR_WIDTH+1];
      unf_any     = unf_any | w[CTR_WIDTH] | r[CTR_WIDTH];
      pending_any = pending_any
                  | (wr_cnt[i] != '0)
                  | (rd_cnt[i] != '0);
    end
  end

  // Traffic is accounted in every state, including IDLE.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        wr_cnt[i] <= '0;
        rd_cnt[i] <= '0;
      end
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else if (ap_reset) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        wr_cnt[i] <= '0;
        rd_cnt[i] <= '0;
      end
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        wr_cnt[i] <= wr_nxt[i];
        rd_cnt[i] <= rd_nxt[i];
      end
      err_overflow  <= (err_overflow & ~start_acc) | ovf_any;
      err_underflow <= (err_underflow & ~start_acc) | unf_any;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state       <= S_IDLE;
      step        <= '0;
      run_cycles  <= '0;
      err_timeout <= 1'b0;
      vx_reset    <= 1'b1;
      ap_idle     <= 1'b1;
      ap_done     <= 1'b0;
    end else if (ap_reset) begin
      state       <= S_IDLE;
      step        <= '0;
      run_cycles  <= '0;
      err_timeout <= 1'b0;
      vx_reset    <= 1'b1;
      ap_idle     <= 1'b1;
      ap_done     <= 1'b0;
    end else begin
      ap_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (ap_start) begin
            state       <= S_RESET;
            step        <= '0;
            run_cycles  <= '0;
            err_timeout <= 1'b0;
            ap_idle     <= 1'b0;
          end
        end
        S_RESET: begin
          if (step == RD_LAST) begin
            state    <= S_WAIT;
            step     <= '0;
            vx_reset <= 1'b0;
          end else begin
            step <= step + STEP_W'(1);
          end
        end
        S_WAIT: begin
          run_cycles <= run_cycles + 64'd1;
          if (vx_busy) begin
            state <= S_RUN;
          end else if (TO_EN && step == TO_LAST) begin
            err_timeout <= 1'b1;
            state       <= S_DRAIN;
          end else begin
            step <= step + STEP_W'(1);
          end
        end
        S_RUN: begin
          run_cycles <= run_cycles + 64'd1;
          if (!vx_busy) state <= S_DRAIN;
        end
        S_DRAIN: begin
          run_cycles <= run_cycles + 64'd1;
          if (!pending_any) begin
            state    <= S_IDLE;
            ap_done  <= 1'b1;
            ap_idle  <= 1'b1;
            vx_reset <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vx_afu_run_ctrl.sv
// Randomized and directed bench for vx_afu_run_ctrl against a
// timestamp-based behavioural model of the run lifecycle.
module tb_vx_afu_run_ctrl;
  localparam int NB  = 2;
  localparam int CW  = 2;
  localparam int RD  = 16;
  localparam int BT  = 8;
  localparam int MAXC = (1 << CW) - 1;

  localparam int P_IDLE  = 0;
  localparam int P_RST   = 1;
  localparam int P_WAIT  = 2;
  localparam int P_RUN   = 3;
  localparam int P_DRAIN = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sreset = 1'b0;
  logic        start = 1'b0;
  logic        busy = 1'b0;
  logic        done, idle, ready, vxr, pend;
  logic        eov, eun, eto;
  logic [63:0] rcyc;

  int n_vec = 0;
  int n_miss = 0;

  vx_afu_run_ctrl_if #(.NUM_BANKS(NB)) bus ();

  vx_afu_run_ctrl #(
    .NUM_BANKS   (NB),
    .CTR_WIDTH   (CW),
    .RESET_DELAY (RD),
    .BUSY_TIMEOUT(BT)
  ) dut (
    .ap_clk       (clk),
    .ap_rst_n     (rst_n),
    .ap_reset     (sreset),
    .ap_start     (start),
    .ap_done      (done),
    .ap_idle      (idle),
    .ap_ready     (ready),
    .vx_reset     (vxr),
    .vx_busy      (busy),
    .axi          (bus),
    .pending_any  (pend),
    .run_cycles   (rcyc),
    .err_overflow (eov),
    .err_underflow(eun),
    .err_timeout  (eto)
  );

  always #5 clk = ~clk;

  // Behavioural model: phases keyed by absolute cycle timestamps.
  int          m_ph = P_IDLE;
  int          m_cyc = 0;
  int          t_fall = 0;
  int          m_wr [NB];
  int          m_rd [NB];
  logic [63:0] m_rc = '0;
  bit          m_done = 0;
  bit          m_eov = 0;
  bit          m_eun = 0;
  bit          m_eto = 0;

  function automatic bit model_pending();
    bit p;
    p = 0;
    for (int i = 0; i < NB; i++)
      if (m_wr[i] != 0 || m_rd[i] != 0) p = 1;
    return p;
  endfunction

  task automatic model_clear();
    m_ph = P_IDLE;
    m_rc = '0;
    m_done = 0;
    m_eov = 0;
    m_eun = 0;
    m_eto = 0;
    for (int i = 0; i < NB; i++) begin
      m_wr[i] = 0;
      m_rd[i] = 0;
    end
  endtask

  initial model_clear();

  always @(posedge clk) begin
    if (rst_n) begin
      bit acc;
      bit ov;
      bit un;
      bit pend0;
      int nw;
      int nr;
      acc = 0;
      ov = 0;
      un = 0;
      pend0 = model_pending();
      m_done = 0;
      if (sreset) begin
        model_clear();
      end else begin
        case (m_ph)
          P_IDLE: if (start) begin
            m_ph = P_RST;
            t_fall = m_cyc + 1 + RD;
            m_rc = '0;
            m_eto = 0;
            acc = 1;
          end
          P_RST: if (m_cyc + 1 == t_fall) m_ph = P_WAIT;
          P_WAIT: begin
            m_rc = m_rc + 1;
            if (busy) m_ph = P_RUN;
            else if (BT != 0 && m_cyc - t_fall + 1 == BT) begin
              m_eto = 1;
              m_ph = P_DRAIN;
            end
          end
          P_RUN: begin
            m_rc = m_rc + 1;
            if (!busy) m_ph = P_DRAIN;
          end
          default: begin
            m_rc = m_rc + 1;
            if (!pend0) begin
              m_ph = P_IDLE;
              m_done = 1;
            end
          end
        endcase
        for (int i = 0; i < NB; i++) begin
          nw = m_wr[i] + int'(bus.awfire[i]) - int'(bus.bfire[i]);
          nr = m_rd[i] + int'(bus.arfire[i])
             - int'(bus.rlastfire[i]);
          if (nw > MAXC) ov = 1;
          else if (nw < 0) un = 1;
          else m_wr[i] = nw;
          if (nr > MAXC) ov = 1;
          else if (nr < 0) un = 1;
          else m_rd[i] = nr;
        end
        if (acc) begin
          m_eov = 0;
          m_eun = 0;
        end
        m_eov = m_eov | ov;
        m_eun = m_eun | un;
      end
      m_cyc++;
    end
  end

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    check("ap_idle", 64'(idle), 64'(m_ph == P_IDLE));
    check("vx_reset", 64'(vxr), 64'(m_ph <= P_RST));
    check("ap_done", 64'(done), 64'(m_done));
    check("ap_ready", 64'(ready), 64'(m_done));
    check("pending_any", 64'(pend), 64'(model_pending()));
    check("run_cycles", rcyc, m_rc);
    check("err_overflow", 64'(eov), 64'(m_eov));
    check("err_underflow", 64'(eun), 64'(m_eun));
    check("err_timeout", 64'(eto), 64'(m_eto));
  endtask

  task automatic clr_pulses();
    bus.awfire = '0;
    bus.bfire = '0;
    bus.arfire = '0;
    bus.rlastfire = '0;
    sreset = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    check_all();
    clr_pulses();
  endtask

  task automatic rand_traffic(input bit drain_only);
    for (int i = 0; i < NB; i++) begin
      if (drain_only) begin
        bus.bfire[i] = m_wr[i] > 0 && $urandom_range(0, 1) == 1;
        bus.rlastfire[i] = m_rd[i] > 0 && $urandom_range(0, 1) == 1;
      end else begin
        bus.awfire[i] = $urandom_range(0, 3) == 0;
        bus.bfire[i] = $urandom_range(0, 3) == 0;
        bus.arfire[i] = $urandom_range(0, 3) == 0;
        bus.rlastfire[i] = $urandom_range(0, 3) == 0;
      end
    end
    sreset = !drain_only && $urandom_range(0, 299) == 0;
  endtask

  initial begin
    clr_pulses();
    #12;
    check_all();
    check("rst_vx_reset", 64'(vxr), 64'd1);
    check("rst_idle", 64'(idle), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) cycle();

    // Nominal run: busy high over cycles 20..38 after the start.
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (15) cycle();
    check("nom_vxr_c16", 64'(vxr), 64'd1);
    cycle();
    check("nom_vxr_c17", 64'(vxr), 64'd0);
    repeat (3) cycle();
    busy = 1'b1;
    repeat (19) cycle();
    busy = 1'b0;
    cycle();
    check("nom_done_c40", 64'(done), 64'd0);
    cycle();
    check("nom_done_c41", 64'(done), 64'd1);
    check("nom_run_cycles", rcyc, 64'd24);
    check("nom_idle", 64'(idle), 64'd1);
    cycle();
    check("nom_done_c42", 64'(done), 64'd0);

    // Drain: done waits for every outstanding response.
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (17) cycle();
    busy = 1'b1;
    repeat (2) cycle();
    for (int k = 0; k < 3; k++) begin
      bus.awfire[1] = 1'b1;
      bus.arfire[0] = (k < 2);
      cycle();
    end
    busy = 1'b0;
    repeat (4) cycle();
    check("drain_pending", 64'(pend), 64'd1);
    for (int k = 0; k < 3; k++) begin
      bus.bfire[1] = 1'b1;
      cycle();
      cycle();
    end
    check("drain_hold", 64'(idle), 64'd0);
    bus.rlastfire[0] = 1'b1;
    cycle();
    bus.rlastfire[0] = 1'b1;
    cycle();
    check("drain_last_nodone", 64'(done), 64'd0);
    cycle();
    check("drain_done", 64'(done), 64'd1);
    repeat (2) cycle();

    // Simultaneous inc/dec, saturation and underflow in IDLE.
    bus.awfire[0] = 1'b1;
    cycle();
    bus.awfire[0] = 1'b1;
    bus.bfire[0] = 1'b1;
    cycle();
    check("simul_pending", 64'(pend), 64'd1);
    repeat (4) begin
      bus.awfire[0] = 1'b1;
      cycle();
    end
    check("sat_overflow", 64'(eov), 64'd1);
    repeat (2) begin
      bus.bfire[0] = 1'b1;
      cycle();
    end
    check("sat_still_pend", 64'(pend), 64'd1);
    bus.bfire[0] = 1'b1;
    cycle();
    check("sat_drained", 64'(pend), 64'd0);
    check("no_underflow", 64'(eun), 64'd0);
    bus.bfire[1] = 1'b1;
    cycle();
    check("underflow_set", 64'(eun), 64'd1);
    check("underflow_cnt0", 64'(pend), 64'd0);

    // Timeout: busy never rises; start clears the earlier flags.
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("start_clr_unf", 64'(eun), 64'd0);
    check("start_clr_ovf", 64'(eov), 64'd0);
    repeat (24) cycle();
    check("to_done_c25", 64'(done), 64'd0);
    cycle();
    check("to_done_c26", 64'(done), 64'd1);
    check("to_flag", 64'(eto), 64'd1);
    repeat (2) cycle();

    // Soft reset in RUN with counters saturated.
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (17) cycle();
    busy = 1'b1;
    repeat (2) cycle();
    repeat (3) begin
      bus.awfire[0] = 1'b1;
      bus.arfire[1] = 1'b1;
      cycle();
    end
    check("mid_pending", 64'(pend), 64'd1);
    sreset = 1'b1;
    cycle();
    check("sreset_idle", 64'(idle), 64'd1);
    check("sreset_vxr", 64'(vxr), 64'd1);
    check("sreset_pend", 64'(pend), 64'd0);
    check("sreset_done", 64'(done), 64'd0);
    busy = 1'b0;
    repeat (3) cycle();

    // Randomized runs.
    for (int r = 0; r < 16; r++) begin
      int wt;
      int rn;
      wt = $urandom_range(0, BT + 3);
      rn = $urandom_range(1, 25);
      busy = 1'b0;
      start = 1'b1;
      rand_traffic(0);
      cycle();
      start = 1'b0;
      repeat (RD + wt) begin
        rand_traffic(0);
        cycle();
      end
      busy = 1'b1;
      repeat (rn) begin
        rand_traffic(0);
        cycle();
      end
      busy = 1'b0;
      repeat (40) begin
        rand_traffic(1);
        cycle();
      end
      repeat ($urandom_range(1, 4)) cycle();
    end

    // Asynchronous reset in the middle of a clock phase.
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (18) cycle();
    busy = 1'b1;
    bus.awfire[1] = 1'b1;
    cycle();
    cycle();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    check("arst_vxr", 64'(vxr), 64'd1);
    check("arst_idle", 64'(idle), 64'd1);
    check("arst_done", 64'(done), 64'd0);
    check("arst_rc", rcyc, 64'd0);
    check("arst_pend", 64'(pend), 64'd0);
    @(negedge clk);
    check_all();
    busy = 1'b0;
    rst_n = 1'b1;
    repeat (3) cycle();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_miss);
    $finish;
  end
endmodule
